// File: rtl/tarea1_in_pkg.sv
// tarea1_in_pkg: shared debounce state encoding and counter sizing helper
package tarea1_in_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} dbnc_state_t;
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tarea1_input_conditioner_bit_synchronizer.sv
// bit_synchronizer: STAGES-deep flop chain bringing an asynchronous bit into the clk domain
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync;
  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= '0;
    else sync <= {sync[STAGES-2:0], d};
  assign q = sync[STAGES-1];
endmodule

// File: rtl/tarea1_input_conditioner.sv
// tarea1_input_conditioner: synchronise/debounce the button and emit one enable pulse with captured A/B per press.
// Define AUTO_REPEAT_EN to repeat the capture and pulse every REPEAT_CYCLES while the button is held.
module tarea1_input_conditioner
  import tarea1_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES = 2,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic sw_a,
  input  logic sw_b,
  output logic A,
  output logic B,
  output logic enable,
  output logic btn_level
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  logic btn_s, a_s, b_s, done, qual, rep, fire;
  logic [CW-1:0] cnt;
  dbnc_state_t state, state_nxt;
  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_btn (.clk(clk), .reset(reset), .d(~btn_n), .q(btn_s));
  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_a (.clk(clk), .reset(reset), .d(sw_a), .q(a_s));
  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_b (.clk(clk), .reset(reset), .d(sw_b), .q(b_s));
  assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         state_nxt = btn_s ? PRESS_WAIT : IDLE;
      PRESS_WAIT:   state_nxt = !btn_s ? IDLE : done ? HELD : PRESS_WAIT;
      HELD:         state_nxt = btn_s ? HELD : RELEASE_WAIT;
      RELEASE_WAIT: state_nxt = btn_s ? HELD : done ? IDLE : RELEASE_WAIT;
      default:      state_nxt = IDLE;
    endcase
  end
`ifdef AUTO_REPEAT_EN
  localparam int RW = cnt_width(REPEAT_CYCLES);
  logic [RW-1:0] rcnt;
  assign rep = state == HELD && btn_s && rcnt == RW'(REPEAT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) rcnt <= '0;
    else rcnt <= (state == HELD && btn_s && !rep) ? rcnt + 1'b1 : '0;
`else
  assign rep = 1'b0;
`endif
  assign qual = (state == PRESS_WAIT && btn_s && done) || rep;
  assign btn_level = state == HELD || state == RELEASE_WAIT;
  // fire marks the capture edge; enable follows one cycle later so A/B lead it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      fire <= 1'b0;
      enable <= 1'b0;
      A <= 1'b0;
      B <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= (state_nxt != state || state == IDLE || state == HELD) ? '0 : cnt + 1'b1;
      fire <= qual;
      enable <= fire;
      if (qual) begin
        A <= a_s;
        B <= b_s;
      end
    end
endmodule

// File: tb/tb_tarea1_input_conditioner.sv
// tb_tarea1_input_conditioner: random and directed button/switch stimulus against a run-length debounce model
module tb_tarea1_input_conditioner;
  localparam int D = 4, S = 2, R = 6;
  logic clk = 0, reset = 1, btn_n = 1, sw_a = 0, sw_b = 0;
  logic A, B, enable, btn_level;
  int total = 0, bad = 0;
  logic hb[$], ha[$], hs[$];
  logic m_level, m_a, m_b, m_en, m_pend;
  int run, rep, pulses;

  tarea1_input_conditioner #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .sw_a(sw_a), .sw_b(sw_b),
    .A(A), .B(B), .enable(enable), .btn_level(btn_level));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    hb = {}; ha = {}; hs = {};
    for (int i = 0; i < S; i++) begin hb.push_back(0); ha.push_back(0); hs.push_back(0); end
    m_level = 0; m_a = 0; m_b = 0; m_en = 0; m_pend = 0; run = 0; rep = 0;
  endtask

  // A level is accepted once the synchronised button disagrees with it for D+1 consecutive edges.
  task automatic model_edge();
    logic ub, ua, us;
    ub = hb.pop_front(); ua = ha.pop_front(); us = hs.pop_front();
    hb.push_back(!btn_n); ha.push_back(sw_a); hs.push_back(sw_b);
    m_en = m_pend;
    m_pend = 0;
`ifdef AUTO_REPEAT_EN
    if (m_level && run == 0 && ub) begin
      if (rep == R - 1) begin rep = 0; m_a = ua; m_b = us; m_pend = 1; end
      else rep++;
    end else rep = 0;
`endif
    if (ub != m_level) begin
      run++;
      if (run == D + 1) begin
        m_level = !m_level;
        run = 0;
        if (m_level) begin m_a = ua; m_b = us; m_pend = 1; end
      end
    end else run = 0;
  endtask

  task automatic step(input logic bn, input logic a, input logic b);
    btn_n = bn; sw_a = a; sw_b = b;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("A", A, m_a);
    check("B", B, m_b);
    check("enable", enable, m_en);
    check("btn_level", btn_level, m_level);
    if (enable) pulses++;
  endtask

  task automatic press(input logic a, input logic b, input int n);
    for (int i = 0; i < n; i++) step(0, a, b);
    for (int i = 0; i < 12; i++) step(1, a, b);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_A", A, 0); check("rst_B", B, 0);
    check("rst_enable", enable, 0); check("rst_level", btn_level, 0);
    @(negedge clk); reset = 0;
    // clean press: capture at edge 7, pulse after edge 8, one pulse only
    pulses = 0;
    for (int e = 1; e <= 20; e++) begin
      step(0, 1, 0);
      if (e == 7) begin check("clean_A_e7", A, 1); check("clean_lvl_e7", btn_level, 1); end
      if (e == 8) check("clean_en_e8", enable, 1);
      if (e == 7 || e == 9) check("clean_en_edge", enable, 0);
    end
    for (int i = 0; i < 10; i++) step(1, 1, 0);
`ifndef AUTO_REPEAT_EN
    check("clean_one_pulse", pulses == 1, 1);
`endif
    // glitch rejection with switches moved so a spurious capture would show
    pulses = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 1);
    check("glitch_no_pulse", pulses == 0, 1);
    check("glitch_A_hold", A, 1);
    // release bounce
    pulses = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    for (int i = 0; i < 10; i++) step(i[1], 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    check("bounce_level", btn_level, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    check("bounce_release", btn_level, 0);
`ifndef AUTO_REPEAT_EN
    check("bounce_one_pulse", pulses == 1, 1);
`endif
    // Tarea1 sequence
    press(1'b0, 1'b1, 15); press(1'b1, 1'b0, 15); press(1'b1, 1'b1, 15); press(1'b0, 1'b0, 15);
    // reset in PRESS_WAIT at cnt=2, then restart qualification with button still low
    for (int i = 0; i < 5; i++) step(0, 1, 1);
    #2 reset = 1;
    #1 check("mid_rst_A", A, 0); check("mid_rst_B", B, 0);
    check("mid_rst_en", enable, 0); check("mid_rst_lvl", btn_level, 0);
    model_reset();
    @(negedge clk); reset = 0;
    for (int e = 1; e <= 12; e++) begin
      step(0, 1, 1);
      if (e == S + D + 2) check("rst_relat_en", enable, 1);
    end
    for (int i = 0; i < 12; i++) step(1, 1, 1);
`ifdef AUTO_REPEAT_EN
    for (int i = 0; i < 30; i++) step(0, 1, i >= 15);
    for (int i = 0; i < 12; i++) step(1, 1, 1);
`endif
    // random segments of stable button level with occasional switch changes
    for (int k = 0; k < 120; k++) begin
      logic bn, a, b;
      int len;
      bn = 1'($urandom_range(0, 1)); a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1));
      len = (($urandom & 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 14);
      for (int i = 0; i < len; i++) begin
        if (($urandom & 7) == 0) a = !a;
        step(bn, a, b);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
